// File: rtl/fpmul_rs_pkg.sv
// ---------------------------------------------------------------------------
// fpmul_rs_pkg
//  Shared definitions for the FP32 multiply reservation station: default tag
//  width, the "no producer" tag, FP32 field widths and the issue FSM states.
// ---------------------------------------------------------------------------
package fpmul_rs_pkg;

  localparam int TAG_W_DEFAULT = 4;
  localparam int TAG_NULL      = 0;   // operand value present, nothing to wait for

  localparam int FP_SIGN_W = 1;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MAN_W  = 23;
  localparam int FP32_W    = FP_SIGN_W + FP_EXP_W + FP_MAN_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,   // waiting for a ready entry
    ST_EXEC = 2'd1,   // operands held on the multiplier, counting latency
    ST_WB   = 2'd2    // product held on the CDB request port until granted
  } rs_state_t;

endpackage

// File: rtl/fpmul_rs_entry.sv
// ---------------------------------------------------------------------------
// fpmul_rs_entry
//  One reservation-station slot: busy flag and two operands, each either a
//  value (q == TAG_NULL) or the tag of the producer still being waited on.
//  Snoops the CDB and also bypasses a broadcast that coincides with the write.
// Ports
//  clk, rst            clock, async active-high reset
//  flush               squash the slot
//  alloc               write a new op into this slot (slot is free)
//  alloc_vj/qj/vk/qk   operand values/tags for the new op
//  free                result of this slot was granted on the CDB
//  cdb_valid/tag/data  CDB broadcast
//  busy                slot holds an op
//  vj, vk              operand values
//  opnd_ready          busy and both operands present
// ---------------------------------------------------------------------------
module fpmul_rs_entry
  import fpmul_rs_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc,
  input  logic [FP32_W-1:0] alloc_vj,
  input  logic [TAG_W-1:0]  alloc_qj,
  input  logic [FP32_W-1:0] alloc_vk,
  input  logic [TAG_W-1:0]  alloc_qk,
  input  logic              free,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [FP32_W-1:0] cdb_data,
  output logic              busy,
  output logic [FP32_W-1:0] vj,
  output logic [FP32_W-1:0] vk,
  output logic              opnd_ready
);

  localparam logic [TAG_W-1:0] NULL_TAG = TAG_W'(TAG_NULL);

  logic [TAG_W-1:0] qj;
  logic [TAG_W-1:0] qk;

  // Broadcast arriving in the same cycle as the op itself.
  logic byp_j, byp_k;
  assign byp_j = cdb_valid && (alloc_qj != NULL_TAG) && (cdb_tag == alloc_qj);
  assign byp_k = cdb_valid && (alloc_qk != NULL_TAG) && (cdb_tag == alloc_qk);

  // Broadcast completing an operand already waiting in the slot.
  logic snoop_j, snoop_k;
  assign snoop_j = busy && cdb_valid && (qj != NULL_TAG) && (cdb_tag == qj);
  assign snoop_k = busy && cdb_valid && (qk != NULL_TAG) && (cdb_tag == qk);

  // NOTE: every register of the slot is reset, not only busy; the slot is a
  // handful of flops, so no stale operand survives a reset.
  // NOTE: sequential state uses non-blocking assignments so all slots and the
  // FSM sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      vj   <= '0;
      qj   <= NULL_TAG;
      vk   <= '0;
      qk   <= NULL_TAG;
    end else if (flush) begin
      busy <= 1'b0;
    end else if (alloc) begin
      busy <= 1'b1;
      vj   <= byp_j ? cdb_data : alloc_vj;
      qj   <= byp_j ? NULL_TAG : alloc_qj;
      vk   <= byp_k ? cdb_data : alloc_vk;
      qk   <= byp_k ? NULL_TAG : alloc_qk;
    end else begin
      if (free) busy <= 1'b0;
      if (snoop_j) begin
        vj <= cdb_data;
        qj <= NULL_TAG;
      end
      if (snoop_k) begin
        vk <= cdb_data;
        qk <= NULL_TAG;
      end
    end
  end

  assign opnd_ready = busy && (qj == NULL_TAG) && (qk == NULL_TAG);

endmodule

// File: rtl/fpmul_reservation_station.sv
// ---------------------------------------------------------------------------
// fpmul_reservation_station
//  Tomasulo reservation station for the FP32 multiplier. Allocates the lowest
//  free slot, dispatches the lowest ready slot to the external combinational
//  multiplier, waits MUL_LATENCY cycles, then holds the product on the CDB
//  request port until granted.
// Ports
//  clk, rst                         clock, async active-high reset
//  flush                            squash all slots and the in-flight op
//  issue_valid/ready/tag            issue handshake, tag of slot to be used
//  issue_vj/qj/vk/qk                operand values / producer tags
//  cdb_valid/tag/data               CDB broadcast snooped by all slots
//  mul_a, mul_b, mul_p              external multiplier interface
//  res_valid/tag/data, res_grant    CDB request and grant
// ---------------------------------------------------------------------------
module fpmul_reservation_station
  import fpmul_rs_pkg::*;
#(
  parameter int NUM_ENTRIES = 3,
  parameter int TAG_W       = TAG_W_DEFAULT,
  parameter int RS_TAG_BASE = 4,
  parameter int MUL_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              issue_valid,
  output logic              issue_ready,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic [FP32_W-1:0] issue_vj,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [FP32_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [FP32_W-1:0] cdb_data,
  output logic [FP32_W-1:0] mul_a,
  output logic [FP32_W-1:0] mul_b,
  input  logic [FP32_W-1:0] mul_p,
  output logic              res_valid,
  output logic [TAG_W-1:0]  res_tag,
  output logic [FP32_W-1:0] res_data,
  input  logic              res_grant
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  rs_state_t        state;
  logic [IDX_W-1:0] exec_idx;
  logic [CNT_W-1:0] cnt;

  logic [NUM_ENTRIES-1:0] ent_busy;
  logic [NUM_ENTRIES-1:0] ent_opnd_ready;
  logic [NUM_ENTRIES-1:0] ent_alloc;
  logic [NUM_ENTRIES-1:0] ent_free;
  logic [FP32_W-1:0]      ent_vj [NUM_ENTRIES];
  logic [FP32_W-1:0]      ent_vk [NUM_ENTRIES];

  logic             any_free;
  logic [IDX_W-1:0] free_idx;
  logic             any_rdy;
  logic [IDX_W-1:0] rdy_idx;

  // Fixed-priority pickers: scanning downward leaves the lowest index.
  // The executing slot stays busy until grant and must not be picked again.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    any_rdy  = 1'b0;
    rdy_idx  = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!ent_busy[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (ent_opnd_ready[i] && !((state != ST_IDLE) && (exec_idx == IDX_W'(i)))) begin
        any_rdy = 1'b1;
        rdy_idx = IDX_W'(i);
      end
    end
  end

  // Busy bits are registered, so a slot freed by this cycle's grant is not
  // visible as free until the next cycle.
  assign issue_ready = any_free;
  assign issue_tag   = any_free ? TAG_W'(RS_TAG_BASE + int'(free_idx)) : TAG_W'(TAG_NULL);

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
    assign ent_alloc[g] = issue_valid && any_free && (free_idx == IDX_W'(g));
    assign ent_free[g]  = (state == ST_WB) && res_grant && (exec_idx == IDX_W'(g));

    fpmul_rs_entry #(
      .TAG_W (TAG_W)
    ) u_entry (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .alloc      (ent_alloc[g]),
      .alloc_vj   (issue_vj),
      .alloc_qj   (issue_qj),
      .alloc_vk   (issue_vk),
      .alloc_qk   (issue_qk),
      .free       (ent_free[g]),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_data   (cdb_data),
      .busy       (ent_busy[g]),
      .vj         (ent_vj[g]),
      .vk         (ent_vk[g]),
      .opnd_ready (ent_opnd_ready[g])
    );
  end

  // Issue FSM. mul_a/mul_b stay put through EXEC so the combinational product
  // is stable when captured; they are only cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      exec_idx  <= '0;
      cnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      res_valid <= 1'b0;
      res_tag   <= '0;
      res_data  <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      res_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_rdy) begin
            mul_a    <= ent_vj[rdy_idx];
            mul_b    <= ent_vk[rdy_idx];
            exec_idx <= rdy_idx;
            cnt      <= CNT_W'(MUL_LATENCY - 1);
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            res_data  <= mul_p;
            res_tag   <= TAG_W'(RS_TAG_BASE + int'(exec_idx));
            res_valid <= 1'b1;
            state     <= ST_WB;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_WB: begin
          if (res_grant) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
